red_pitaya_mux_sampler: RTL
===========================

// Module: red_pitaya_mux_sampler
// PURPOSE
//  Downstream of the analog-mux controller: takes the raw ADC stream plus the controller's mux address and settle flag.
//  Once the mux has settled on a channel, averages 2^k ADC samples and tags the mean with the channel index.
//  Publishes the mean as a one-cycle strobe and in a per-channel result bank.
//  Feeds the FADS detection/threshold logic, which reads per-detector levels without knowing the mux timing.
// PARAMETERS
//  CHNL      6   number of detectors/channels (mux positions 0..CHNL-1)
//  MAW       3   mux address width
//  ADW       14  ADC sample width, two's complement
//  MAX_LOG2  6   max averaging exponent; accumulator width = ADW+MAX_LOG2
// PORTS
//  adc_clk_i          in   1            ADC clock, all logic on rising edge
//  adc_rstn_i         in   1            synchronous reset, active low
//  adc_dat_i          in   ADW          signed ADC sample, one per clock
//  mux_addr_i         in   MAW          current mux address from mux controller
//  signal_stable_i    in   1            level: mux output settled on mux_addr_i
//  active_channels_i  in   CHNL         channel enable mask (same mask the controller uses)
//  avg_log2_i         in   3            averaging exponent k; effective k = min(avg_log2_i, MAX_LOG2)
//  smp_valid_o        out  1            one-cycle strobe: new channel mean available
//  smp_chan_o         out  MAW          channel index of the strobed mean
//  smp_dat_o          out  ADW          strobed mean, signed
//  ch_dat_o           out  CHNL*ADW     result bank; channel c in bits [c*ADW +: ADW]
//  frame_done_o       out  1            one-cycle strobe: every active channel updated since last frame_done
//  drop_cnt_o         out  16           count of aborted windows, saturating
// BEHAVIOUR
//  Reset (adc_rstn_i=0 at clock edge): all outputs 0, ch_dat_o all 0, frame mask cleared, state WAIT.
//  mux_addr_i and signal_stable_i are registered once (addr_q, stab_q); state machine runs on the registered copies.
//  State machine: WAIT -> ACCUM -> HOLD.
//   - WAIT: on stab_q=1 and active_channels_i[addr_q]=1, latch chan=addr_q and k; clear acc and cnt; go ACCUM.
//     The first sample is accumulated in that same cycle.
//   - ACCUM: acc += sign-extended adc_dat_i; cnt++.
//     When cnt reaches 2^k samples, write result = acc >>> k (arithmetic, truncating toward -inf).
//     Result goes to smp_dat_o and ch_dat_o[chan]; assert smp_valid_o for 1 cycle; go HOLD.
//   - HOLD: ignore samples until addr_q != chan, then go WAIT. Exactly one mean per mux dwell.
//  Latency: smp_valid_o rises 2 cycles after the clock that samples the 2^k-th accumulated input.
//   One cycle is for input registration, one for the output register.
//   k=0 means a single sample; the mean equals that sample.
//  Abort: in ACCUM, if addr_q != chan or stab_q=0, discard acc and go WAIT.
//   No strobe, ch_dat_o unchanged; drop_cnt_o++ (saturates at 16'hFFFF).
//  Inactive channel (mask bit 0): never sampled; its ch_dat_o entry keeps its last value.
//  Frame: per-channel done-mask bit set on each strobe.
//   When (done_mask & active_channels_i) == active_channels_i and the mask is nonzero:
//   frame_done_o pulses 1 cycle, coincident with that smp_valid_o, and done_mask clears.
//   active_channels_i = 0 -> frame_done_o never asserts.
//  avg_log2_i changes take effect at the next WAIT->ACCUM transition only.
//  Accumulator cannot overflow: 2^MAX_LOG2 * full-scale fits ADW+MAX_LOG2 bits signed.
//  Reset mid-ACCUM: window discarded, drop_cnt_o cleared with everything else.
// CONFIGURATION
//  MUX_SAMPLER_PEAK_EN defined:
//   - adds output ch_peak_o [CHNL*ADW]: per-channel max of raw samples seen in the last completed window.
//   - Written on the same cycle as ch_dat_o; aborted windows do not update it; reset value is most-negative code.
//  MUX_SAMPLER_PEAK_EN undefined: port and peak registers are absent; all other behaviour is identical.
// TESTING
//  1. mask=6'b000011, k=2, channel 0 fed const 100, channel 1 fed const -8, stable after 26 clk
//     -> strobes ch0=100, then ch1=-8; frame_done_o pulses with the ch1 strobe.
//  2. k=3, ramp 0..7 on ch2 -> smp_dat_o=3 (28>>3); smp_valid_o 2 clk after the 8th sample.
//  3. mux address changes after 2 of 4 samples -> no strobe, drop_cnt_o=1, ch_dat_o unchanged.
//  4. mask bit 4 cleared with mux parked on ch4, stable=1 for 1000 clk -> no strobe, ch_dat_o[4] stays 0.
//  5. k=6, constant -8192 -> mean -8192 exactly (no overflow); avg_log2_i=7 behaves as 6.
//  6. Assert reset during ACCUM -> next clk all outputs 0; first window after release produces a correct mean.
//     With MUX_SAMPLER_PEAK_EN: samples {5,-3,9,1} -> ch_peak_o entry = 9.

Source files
------------

// File: rtl/red_pitaya_mux_sampler.sv
// Averages 2^k ADC samples per settled mux dwell and publishes tagged channel means.
// Define MUX_SAMPLER_PEAK_EN to add the per-channel window peak bank (ch_peak_o).
module red_pitaya_mux_sampler #(
  parameter int CHNL     = 6,
  parameter int MAW      = 3,
  parameter int ADW      = 14,
  parameter int MAX_LOG2 = 6
) (
  input  logic                adc_clk_i,
  input  logic                adc_rstn_i,
  input  logic [ADW-1:0]      adc_dat_i,
  input  logic [MAW-1:0]      mux_addr_i,
  input  logic                signal_stable_i,
  input  logic [CHNL-1:0]     active_channels_i,
  input  logic [2:0]          avg_log2_i,
  output logic                smp_valid_o,
  output logic [MAW-1:0]      smp_chan_o,
  output logic [ADW-1:0]      smp_dat_o,
  output logic [CHNL*ADW-1:0] ch_dat_o,
  output logic                frame_done_o,
`ifdef MUX_SAMPLER_PEAK_EN
  output logic [CHNL*ADW-1:0] ch_peak_o,
`endif
  output logic [15:0]         drop_cnt_o
);
  localparam int AW = ADW + MAX_LOG2;
  localparam int CW = MAX_LOG2 + 1;
  localparam int NA = 2**MAW;

  // state   | meaning
  // S_WAIT  | idle until the mux is stable on an active channel
  // S_ACCUM | summing 2^k samples; any address change or instability aborts
  // S_HOLD  | mean published, ignore samples until the mux moves on
  typedef enum logic [1:0] {S_WAIT, S_ACCUM, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [MAW-1:0]      addr_q, chan_q, chan_d, pend_chan_q, pend_chan_d, smp_chan_q, smp_chan_d;
  logic                stab_q, pend_q, pend_d, smp_valid_q, smp_valid_d, frame_q, frame_d;
  logic [ADW-1:0]      dat_q, pend_dat_q, pend_dat_d, smp_dat_q, smp_dat_d, acc_shr;
  logic [2:0]          k_q, k_d, k_in;
  logic [AW-1:0]       acc_q, acc_d, dat_ext, acc_sum;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc, cnt_tgt;
  logic [15:0]         drop_q, drop_d;
  logic [CHNL-1:0]     done_q, done_d, done_set;
  logic [CHNL*ADW-1:0] ch_dat_q, ch_dat_d;
  logic [NA-1:0]       act_pad;
  logic                chan_ok;

  always_comb begin
    act_pad = '0;
    act_pad[CHNL-1:0] = active_channels_i;
    chan_ok = stab_q && act_pad[addr_q];
    dat_ext = {{MAX_LOG2{dat_q[ADW-1]}}, dat_q};
    acc_sum = acc_q + dat_ext;
    cnt_inc = cnt_q + CW'(1);
    cnt_tgt = CW'(1) << k_q;
    acc_shr = ADW'($signed(acc_sum) >>> k_q);
    k_in    = (avg_log2_i > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : avg_log2_i;
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    k_d         = k_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    pend_d      = 1'b0;
    pend_chan_d = pend_chan_q;
    pend_dat_d  = pend_dat_q;
    case (state_q)
      S_WAIT: begin
        if (chan_ok) begin
          chan_d = addr_q;
          k_d    = k_in;
          acc_d  = dat_ext;
          cnt_d  = CW'(1);
          if (k_in == 3'd0) begin
            state_d     = S_HOLD;
            pend_d      = 1'b1;
            pend_chan_d = addr_q;
            pend_dat_d  = dat_q;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (!stab_q || addr_q != chan_q) begin
          state_d = S_WAIT;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == cnt_tgt) begin
            state_d     = S_HOLD;
            pend_d      = 1'b1;
            pend_chan_d = chan_q;
            pend_dat_d  = acc_shr;
          end
        end
      end
      S_HOLD: begin
        if (addr_q != chan_q) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Output stage: publish the pending mean and track frame completion.
  always_comb begin
    smp_valid_d = pend_q;
    smp_chan_d  = smp_chan_q;
    smp_dat_d   = smp_dat_q;
    ch_dat_d    = ch_dat_q;
    done_set    = done_q;
    done_d      = done_q;
    frame_d     = 1'b0;
    if (pend_q) begin
      smp_chan_d = pend_chan_q;
      smp_dat_d  = pend_dat_q;
      for (int c = 0; c < CHNL; c++) begin
        if (pend_chan_q == MAW'(c)) begin
          ch_dat_d[c*ADW +: ADW] = pend_dat_q;
          done_set[c] = 1'b1;
        end
      end
      if (active_channels_i != '0 && (done_set & active_channels_i) == active_channels_i) begin
        frame_d = 1'b1;
        done_d  = '0;
      end else begin
        done_d = done_set;
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      addr_q      <= '0;
      stab_q      <= 1'b0;
      dat_q       <= '0;
      state_q     <= S_WAIT;
      chan_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      drop_q      <= '0;
      pend_q      <= 1'b0;
      pend_chan_q <= '0;
      pend_dat_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_chan_q  <= '0;
      smp_dat_q   <= '0;
      ch_dat_q    <= '0;
      done_q      <= '0;
      frame_q     <= 1'b0;
    end else begin
      addr_q      <= mux_addr_i;
      stab_q      <= signal_stable_i;
      dat_q       <= adc_dat_i;
      state_q     <= state_d;
      chan_q      <= chan_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      pend_q      <= pend_d;
      pend_chan_q <= pend_chan_d;
      pend_dat_q  <= pend_dat_d;
      smp_valid_q <= smp_valid_d;
      smp_chan_q  <= smp_chan_d;
      smp_dat_q   <= smp_dat_d;
      ch_dat_q    <= ch_dat_d;
      done_q      <= done_d;
      frame_q     <= frame_d;
    end
  end

`ifdef MUX_SAMPLER_PEAK_EN
  logic [ADW-1:0]      win_pk_q, win_pk_d, pend_pk_q, pend_pk_d, pk_max;
  logic [CHNL*ADW-1:0] ch_pk_q, ch_pk_d;

  always_comb begin
    pk_max    = ($signed(dat_q) > $signed(win_pk_q)) ? dat_q : win_pk_q;
    win_pk_d  = win_pk_q;
    pend_pk_d = pend_pk_q;
    ch_pk_d   = ch_pk_q;
    if (state_q == S_WAIT && chan_ok) begin
      win_pk_d  = dat_q;
      pend_pk_d = dat_q;
    end else if (state_q == S_ACCUM) begin
      win_pk_d  = pk_max;
      pend_pk_d = pk_max;
    end
    if (pend_q) begin
      for (int c = 0; c < CHNL; c++) begin
        if (pend_chan_q == MAW'(c)) ch_pk_d[c*ADW +: ADW] = pend_pk_q;
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      win_pk_q  <= '0;
      pend_pk_q <= '0;
      ch_pk_q   <= {CHNL{1'b1, {(ADW-1){1'b0}}}};
    end else begin
      win_pk_q  <= win_pk_d;
      pend_pk_q <= pend_pk_d;
      ch_pk_q   <= ch_pk_d;
    end
  end

  assign ch_peak_o = ch_pk_q;
`endif

  assign smp_valid_o  = smp_valid_q;
  assign smp_chan_o   = smp_chan_q;
  assign smp_dat_o    = smp_dat_q;
  assign ch_dat_o     = ch_dat_q;
  assign frame_done_o = frame_q;
  assign drop_cnt_o   = drop_q;
endmodule
